muldiv_seq: RTL and testbench

//  Iterative unsigned multiply/divide sequencer for the multicycle core's EX stage (MUL, MULHU, DIVU, REMU).

---
 rtl/muldiv_seq.sv | 139 +++++++++++++
 tb/tb_muldiv_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer.
// Borrows an external 32-bit adder_sub, one add or subtract per cycle.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  output logic            add_mode,
  input  logic [XLEN-1:0] add_result,
  input  logic            add_cout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  // hi: product high half / partial remainder
  // lo: product low half (multiplier) / quotient (dividend)
  // opb: multiplicand / divisor
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            is_div;
  logic            qbit;
  logic [XLEN-1:0] div_a;

  assign is_div = op_q[1];
  assign div_a  = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
  // Top bit set means the shifted remainder exceeds any divisor.
  assign qbit   = hi_q[XLEN-1] | add_cout;

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = res_q;

  // Adder operands: driven only while iterating, zero otherwise
  always_comb begin
    add_a    = '0;
    add_b    = '0;
    add_mode = 1'b0;
    if (state_q == S_RUN) begin
      add_a    = is_div ? div_a : hi_q;
      add_b    = opb_q;
      add_mode = is_div;
    end
  end

  // Next-state and datapath update for one iteration
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          op_d    = op;
          hi_d    = '0;
          lo_d    = op[1] ? operand_a : operand_b;
          opb_d   = op[1] ? operand_b : operand_a;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div) begin
            hi_d = qbit ? add_result : div_a;
            lo_d = {lo_q[XLEN-2:0], qbit};
          end else if (lo_q[0]) begin
            hi_d = {add_cout, add_result[XLEN-1:1]};
            lo_d = {add_result[0], lo_q[XLEN-1:1]};
          end else begin
            hi_d = {1'b0, hi_q[XLEN-1:1]};
            lo_d = {hi_q[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            res_d   = op_q[0] ? hi_d : lo_d;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural adder_sub
// and a queue scoreboard of expected results.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_mode;
  logic [31:0] add_result;
  logic        add_cout;

  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  muldiv_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_mode   (add_mode),
    .add_result (add_result),
    .add_cout   (add_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External adder_sub: A+B or A+~B+1, with carry out
  always_comb begin
    logic [32:0] s;
    if (add_mode) s = {1'b0, add_a} + {1'b0, ~add_b} + 33'd1;
    else          s = {1'b0, add_a} + {1'b0, add_b};
    add_result = s[31:0];
    add_cout   = s[32];
  end

  function automatic logic [31:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFFFFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b);
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    exp_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // n0 = cycles since the accept edge at the current negedge
  task automatic wait_done(input string tag, input int n0);
    int n;
    int bcnt;
    bit got;
    logic [31:0] e;
    n    = n0;
    bcnt = 0;
    got  = 1'b0;
    while (!got && n <= 40) begin
      if (busy) bcnt++;
      if (done) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_latency"}, 32'(n), 32'd33);
      if (exp_q.size() == 0) e = 'x;
      else e = exp_q.pop_front();
      check({tag, "_result"}, result, e);
      @(negedge clk);
      check({tag, "_pulse_end"}, {30'b0, busy, done}, 32'd0);
      check({tag, "_busy_cycles"}, 32'(bcnt + n0 - 1), 32'd33);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    op        = 2'd0;
    operand_a = '0;
    operand_b = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_add", add_a | add_b | 32'(add_mode), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: MUL 7*6 with latency and busy width
    launch(2'd0, 32'd7, 32'd6);
    check("mul_run_add_b", add_b, 32'd7);
    check("mul_run_mode", 32'(add_mode), 32'd0);
    wait_done("mul7x6", 1);
    check("idle_add", add_a | add_b | 32'(add_mode), 32'd0);

    // 2: all-ones square, back-to-back
    launch(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("mul_ff", 1);
    launch(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("mulhu_ff", 1);

    // 3: divide, including remainder top-bit path
    launch(2'd2, 32'd100, 32'd7);
    check("div_run_mode", 32'(add_mode), 32'd1);
    wait_done("divu_100_7", 1);
    launch(2'd3, 32'd100, 32'd7);
    wait_done("remu_100_7", 1);
    launch(2'd2, 32'hFFFFFFFF, 32'h80000001);
    wait_done("divu_big", 1);
    launch(2'd3, 32'hFFFFFFFF, 32'h80000001);
    wait_done("remu_big", 1);

    // 4: divide by zero; abort with start in IDLE loses to start
    abort = 1'b1;
    launch(2'd2, 32'd5, 32'd0);
    abort = 1'b0;
    wait_done("divu_by0", 1);
    launch(2'd3, 32'd5, 32'd0);
    wait_done("remu_by0", 1);

    // 5a: start during RUN is ignored
    launch(2'd0, 32'd1000, 32'd1000);
    repeat (4) @(negedge clk);
    op        = 2'd2;
    operand_a = 32'd77;
    operand_b = 32'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mul_ign_start", 6);

    // 5b: abort at RUN cycle 10
    launch(2'd0, 32'd11, 32'd13);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", result, 32'd1000000);
    void'(exp_q.pop_front());
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);

    // 6: async reset mid-operation, then recovery
    launch(2'd0, 32'h12345678, 32'd9);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_add", add_a | add_b | 32'(add_mode), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(2'd0, 32'd3, 32'd3);
    wait_done("mul3x3", 1);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
